// File: rtl/tmatrix_loader_if.sv
// tmatrix_loader_if: input word stream plus SRAM write-port bundle for the loader.
interface tmatrix_loader_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_own;
    logic [ADDR_W-1:0] wrAddress;
    logic              WE;
    logic [DATA_W-1:0] writebus;
    modport master (output in_valid, in_data, input in_ready, wr_own, wrAddress, WE, writebus);
    modport slave  (input in_valid, in_data, output in_ready, wr_own, wrAddress, WE, writebus);
endinterface

// File: rtl/tmatrix_loader.sv
// tmatrix_loader: streams T-matrix words into SRAM, pulses go, then supervises the MyDesign run.
module tmatrix_loader #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int BASE_ADDR = 0,
    parameter int NUM_WORDS = 28,
    parameter int TIMEOUT   = 100000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    tmatrix_loader_if.slave        s,
    output logic                   go,
    input  logic                   finished,
    input  logic                   overflow,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [31:0]            cycle_count,
    output logic [15:0]            ovf_count
);
    typedef enum logic [1:0] {IDLE, LOAD, GO, WAIT} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d, addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [31:0]       cc_q, cc_d;
    logic [15:0]       oc_q, oc_d;
    logic              rdy_q, rdy_d, own_q, own_d, we_q, we_d, go_q, go_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d, accept;

    assign accept = s.in_valid & rdy_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cc_d    = cc_q;
        oc_d    = oc_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                idx_d   = '0;
                cc_d    = '0;
                oc_d    = '0;
            end
            LOAD: if (accept) begin
                we_d    = 1'b1;
                addr_d  = ADDR_W'(BASE_ADDR) + idx_q;
                data_d  = s.in_data;
                idx_d   = idx_q + ADDR_W'(1);
                state_d = (idx_q == ADDR_W'(NUM_WORDS - 1)) ? GO : LOAD;
            end
            GO: state_d = WAIT;
            WAIT: begin
                // the cycle that sees finished is itself counted
                cc_d = (cc_q == '1) ? cc_q : cc_q + 32'd1;
                oc_d = (overflow && oc_q != '1) ? oc_q + 16'd1 : oc_q;
                if (finished) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (TIMEOUT != 0 && cc_d == 32'(TIMEOUT)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
        endcase
        rdy_d  = state_d == LOAD;
        own_d  = state_d == LOAD || state_d == GO;
        go_d   = state_d == GO;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cc_q    <= '0;
            oc_q    <= '0;
            rdy_q   <= 1'b0;
            own_q   <= 1'b0;
            we_q    <= 1'b0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cc_q    <= cc_d;
            oc_q    <= oc_d;
            rdy_q   <= rdy_d;
            own_q   <= own_d;
            we_q    <= we_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign s.in_ready   = rdy_q;
    assign s.wr_own     = own_q;
    assign s.WE         = we_q;
    assign s.wrAddress  = addr_q;
    assign s.writebus   = data_q;
    assign go           = go_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign cycle_count  = cc_q;
    assign ovf_count    = oc_q;
endmodule

// File: doc/tmatrix_loader.md
Name: tmatrix_loader

Overview:
- Upstream feeder for MyDesign, the tridiagonal inversion core.
- Accepts the T-matrix input words over a valid/ready stream and writes them into SRAM_1R1W through the shared write port, at addresses BASE_ADDR..BASE_ADDR+NUM_WORDS-1.
- Once loading completes, pulses go for one cycle, then supervises the run until finished.
- Reports run cycle count, overflow count, and a timeout error, replacing the bench-side load/go/count logic in silicon.

Parameters:
ADDR_W, 7, SRAM address width
DATA_W, 32, SRAM word width
BASE_ADDR, 0, first SRAM address written
NUM_WORDS, 28, words per load, range 1..2^ADDR_W-BASE_ADDR
TIMEOUT, 100000, max WAIT cycles before err; 0 disables

Ports:
clock  in  1  single design clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  begin a load; sampled only in IDLE
in_valid  in  1  input word valid
in_data  in  DATA_W  input word
in_ready  out  1  loader accepts a word this cycle
wr_own  out  1  loader owns the SRAM write port; external mux selects loader when high
wrAddress  out  ADDR_W  SRAM write address
WE  out  1  SRAM write enable
writebus  out  DATA_W  SRAM write data
go  out  1  one-cycle start pulse to MyDesign
finished  in  1  one-cycle completion pulse from MyDesign
overflow  in  1  overflow flag from MyDesign, sampled per cycle
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse on timeout
cycle_count  out  32  cycles spent in WAIT for the last run
ovf_count  out  16  overflow-high cycles during the last run, saturating

Behaviour:
Reset values:
- All outputs 0; state IDLE; word index 0.

States:
- IDLE: start=1 moves to LOAD; index, cycle_count and ovf_count clear to 0. Otherwise stays in IDLE; counts hold their last-run values.
- LOAD:
  - in_ready=1, decoded from state only (no dependence on in_valid).
  - A word is accepted on in_valid & in_ready.
  - Write latency is 1 cycle: in the cycle after an accept, WE=1, wrAddress=BASE_ADDR+index (index taken before increment), writebus=the accepted word.
  - No accept in a cycle gives WE=0 in the next cycle; wrAddress and writebus hold.
  - The accept of word NUM_WORDS-1 moves to GO, so in_ready is 0 in the next cycle.
  - wr_own=1 in LOAD, and in GO so the final write completes.
- GO:
  - Lasts exactly one cycle with go=1; the final WE also occurs in this cycle. The last word is in SRAM at the same edge MyDesign samples go.
  - Moves to WAIT; wr_own=0 from WAIT onward.
- WAIT:
  - cycle_count increments every cycle, counting the cycle in which finished is seen. It saturates at 2^32-1.
  - ovf_count increments on each cycle with overflow=1 and saturates at 16'hFFFF.
  - finished=1 moves to IDLE with done=1 for one cycle; counts freeze.
  - If TIMEOUT!=0 and cycle_count reaches TIMEOUT without finished, moves to IDLE with err=1 for one cycle.
- done and err are registered and never both high.

Boundary rules:
- start outside IDLE is ignored.
- in_valid outside LOAD is ignored; no write occurs.
- finished and overflow outside WAIT are ignored.
- start and finished in the same cycle (while in WAIT): finished wins, and the start is dropped.
- Asserting reset mid-operation immediately forces IDLE, WE=0, go=0, wr_own=0. A partial load is abandoned; a fresh start reloads all NUM_WORDS words.
- NUM_WORDS=1: a single accept leads directly to GO.
- wrAddress never exceeds BASE_ADDR+NUM_WORDS-1.

Test Plan:
- Back-to-back load: start, then 28 consecutive valid words 0x00000001..0x0000001C -> WE high for 28 consecutive cycles writing addresses 0..27 with matching data; go high exactly once, in the cycle of the write to address 27; in_ready low afterwards.
- Bubbled load: in_valid toggles 1,0,1,0 across 56 cycles -> exactly 28 writes to addresses 0..27 in order; WE low in the cycle after each bubble; go after the 28th write.
- Run accounting: finished asserted 500 cycles after go; overflow high for 3 cycles during the run -> done pulses once; cycle_count=500; ovf_count=3; busy low afterwards.
- Timeout: TIMEOUT=50 and finished never asserted -> err pulses when cycle_count=50; state returns to IDLE; done stays 0.
- Reset mid-load: reset pulsed after 10 accepted words -> all outputs 0 asynchronously; a new start plus 28 words rewrites addresses 0..27, starting from address 0.
- Protocol noise: start while in WAIT, in_valid while in IDLE, and finished while in LOAD -> no state change, no writes, no extra go/done pulses.
